alu_stage: RTL and testbench
============================

ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 reset  in  1  synchronous, active-low; sampled at posedge clk.
REQ-003 stall_in, flush_in  in  1 each  hazard-unit hold / squash of the D->ALU register.
REQ-004 rs1_data_in, rs2_data_in, imm_in, pc_in  in  XLEN each  decoded operands and PC.
REQ-005 alu_op_in  in  alu_op_e  ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU,MUL,PASS_B.
REQ-006 alu_src_in  in  1  0: operand B = rs2; 1: operand B = imm.
REQ-007 branch_in, jump_in  in  1 each  conditional branch (BEQ on zero) / unconditional jump.
REQ-008 rd_in  in  REGMSB; reg_write_in, mem_write_in  in  1; result_src_in  in  result_src_e; data_size_in  in  data_size_e; xcpt_in  in  xcpt_e  decode control.
REQ-009 alu_res_out, write_data_out, pc_plus4_out  out  XLEN each  result, store data (rs2), PC+4 to cache stage.
REQ-010 alu_valid_out  out  1  alu_res_out is final and forwardable this cycle.
REQ-011 rd_out, reg_write_out, mem_write_out, result_src_out, data_size_out, xcpt_out  out  as inputs  registered control passed to cache stage.
REQ-012 branch_taken_out  out  1; branch_target_out  out  XLEN  redirect request to fetch.
REQ-013 busy_out  out  1  multi-cycle op in progress; hazard unit stalls upstream.

Function
REQ-014 D->ALU register loads all inputs when ~stall_in & ~busy_out; holds otherwise.
REQ-015 flush_in (no stall) loads a bubble: all control zero, data zero, xcpt NONE; flush overrides stall and busy.
REQ-016 Operand A = rs1; operand B = imm if alu_src else rs2; write_data_out = registered rs2.
REQ-017 Shifts use B[4:0]; SLT signed, SLTU unsigned, result 0/1 zero-extended; ADD/SUB wrap modulo 2^XLEN.
REQ-018 All outputs are combinational from registered state; no added latency for single-cycle ops.
REQ-019 MUL: result = low XLEN bits of A*B, computed via 4-cycle iterative unit (8 bits of B per cycle, shift-add).
REQ-020 FSM IDLE->MUL_RUN when registered op = MUL & reg valid; 2-bit counter 0..3; MUL_RUN->DONE after count 3; DONE->IDLE when register next loads.
REQ-021 busy_out = 1 in IDLE cycle of MUL entry and MUL_RUN; 0 in DONE. MUL result therefore appears 4 cycles after entry.
REQ-022 alu_valid_out = 0 while busy_out, for bubbles, and when result_src_out = FROM_C; 1 otherwise.
REQ-023 pc_plus4_out = pc + 4; branch_target_out = pc + imm, except jump with alu_src=1 (JALR): (rs1 + imm) & ~1.
REQ-024 branch_taken_out = jump | (branch & (A - B == 0)); forced 0 for bubbles and when xcpt_out != NONE.
REQ-025 Load/store with address misaligned for data_size (HALF: bit0; WORD: bits[1:0]) and xcpt_in NONE: xcpt_out = ADDR_MISALIGN, mem_write_out and reg_write_out forced 0.
REQ-026 Incoming xcpt_in != NONE passes unchanged and has priority; mem_write_out and reg_write_out forced 0.
REQ-027 stall_in during DONE: result held stable, busy_out stays 0, FSM stays DONE.
REQ-028 flush_in during MUL_RUN: multiply aborted, counter cleared, FSM->IDLE, busy_out 0 next cycle.

Reset
REQ-029 reset=0 at posedge: register bubble, FSM IDLE, counter 0, accumulator 0.
REQ-030 After reset all outputs 0 / NONE, including busy_out, alu_valid_out, branch_taken_out, pc_plus4_out = 4.
REQ-031 Reset mid-MUL aborts identically to flush; no partial result is ever marked valid.

Verification
REQ-032 ADD rs1=0xFFFFFFFF, rs2=1 -> alu_res_out 0, alu_valid_out 1 next cycle; SRA 0x80000000 by 0x21 -> 0xC0000000.
REQ-033 MUL 0x00012345 * 0x00000100 -> busy_out 1 for 4 cycles, then alu_res_out 0x01234500, alu_valid_out 1, busy_out 0.
REQ-034 MUL in flight, flush_in pulse in cycle 2 -> busy_out 0 next cycle, bubble output, no valid result.
REQ-035 BEQ pc=0x100, imm=0x20, rs1=rs2=5 -> branch_taken_out 1, target 0x120; JALR rs1=0x203, imm=0 -> target 0x202.
REQ-036 WORD store at address 0x1002 -> xcpt_out ADDR_MISALIGN, mem_write_out 0; with xcpt_in ILLEGAL -> xcpt_out ILLEGAL.
REQ-037 Assert reset=0 during MUL_RUN, release -> all outputs zero/NONE, busy_out 0, first new ADD completes in 1 cycle.

Source files
------------

// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - ALU execute stage: D->ALU register, ALU, 4-cycle multiplier, branch resolve
`timescale 1ns/1ps

package alu_stage_pkg;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {FROM_ALU, FROM_C, FROM_PC4} result_src_e;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} data_size_e;
    typedef enum logic [1:0] {XCPT_NONE, XCPT_ILLEGAL, XCPT_ADDR_MISALIGN, XCPT_ECALL} xcpt_e;
endpackage

module alu_stage
    import alu_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic [XLEN-1:0]   rs1_data_in,
    input  logic [XLEN-1:0]   rs2_data_in,
    input  logic [XLEN-1:0]   imm_in,
    input  logic [XLEN-1:0]   pc_in,
    input  alu_op_e           alu_op_in,
    input  logic              alu_src_in,
    input  logic              branch_in,
    input  logic              jump_in,
    input  logic [REGW-1:0]   rd_in,
    input  logic              reg_write_in,
    input  logic              mem_write_in,
    input  result_src_e       result_src_in,
    input  data_size_e        data_size_in,
    input  xcpt_e             xcpt_in,
    output logic [XLEN-1:0]   alu_res_out,
    output logic [XLEN-1:0]   write_data_out,
    output logic [XLEN-1:0]   pc_plus4_out,
    output logic              alu_valid_out,
    output logic [REGW-1:0]   rd_out,
    output logic              reg_write_out,
    output logic              mem_write_out,
    output result_src_e       result_src_out,
    output data_size_e        data_size_out,
    output xcpt_e             xcpt_out,
    output logic              branch_taken_out,
    output logic [XLEN-1:0]   branch_target_out,
    output logic              busy_out
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        alu_op_e           op;
        logic              alu_src;
        logic              branch;
        logic              jump;
        logic [REGW-1:0]   rd;
        logic              reg_write;
        logic              mem_write;
        result_src_e       result_src;
        data_size_e        data_size;
        xcpt_e             xcpt;
    } stage_t;

    typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DONE} mul_state_e;

    stage_t            stage_q, stage_d;
    mul_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;

    logic [XLEN-1:0]   op_a, op_b, alu_res;
    logic [4:0]        shamt, byte_sh;
    logic [7:0]        mul_byte;
    logic [XLEN-1:0]   mul_partial;
    logic              mul_entry, busy, mem_access, misaligned;

    assign op_a      = stage_q.rs1;
    assign op_b      = stage_q.alu_src ? stage_q.imm : stage_q.rs2;
    assign shamt     = op_b[4:0];
    assign mul_entry = stage_q.valid && (stage_q.op == ALU_MUL) && (state_q == S_IDLE);
    assign busy      = mul_entry || (state_q == S_MUL_RUN);

    // One byte of B per cycle: partial product of A and that byte, shifted into place
    assign byte_sh     = {cnt_q, 3'b000};
    assign mul_byte    = 8'(op_b >> byte_sh);
    assign mul_partial = (op_a * {{(XLEN-8){1'b0}}, mul_byte}) << byte_sh;

    // Capture decode outputs as a live instruction
    always_comb begin
        stage_d            = '0;
        stage_d.valid      = 1'b1;
        stage_d.rs1        = rs1_data_in;
        stage_d.rs2        = rs2_data_in;
        stage_d.imm        = imm_in;
        stage_d.pc         = pc_in;
        stage_d.op         = alu_op_in;
        stage_d.alu_src    = alu_src_in;
        stage_d.branch     = branch_in;
        stage_d.jump       = jump_in;
        stage_d.rd         = rd_in;
        stage_d.reg_write  = reg_write_in;
        stage_d.mem_write  = mem_write_in;
        stage_d.result_src = result_src_in;
        stage_d.data_size  = data_size_in;
        stage_d.xcpt       = xcpt_in;
    end

    // D->ALU register: bubble on reset/flush, hold on stall or multiply in progress
    always_ff @(posedge clk) begin
        if (!reset || flush_in) begin
            stage_q <= '0;
        end else if (!stall_in && !busy) begin
            stage_q <= stage_d;
        end
    end

    // Multiplier state, byte counter and accumulator
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Multiplier next state: entry cycle handles byte 0, MUL_RUN handles bytes 1..3
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (flush_in) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mul_entry) begin
                        acc_d   = mul_partial;
                        cnt_d   = cnt_q + 2'd1;
                        state_d = S_MUL_RUN;
                    end
                end
                S_MUL_RUN: begin
                    acc_d = acc_q + mul_partial;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_DONE;
                        cnt_d   = 2'd0;
                    end
                end
                S_DONE: begin
                    if (!stall_in) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ALU result from registered operands; MUL reads the finished accumulator
    always_comb begin
        alu_res = '0;
        case (stage_q.op)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_OR:     alu_res = op_a | op_b;
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SLL:    alu_res = op_a << shamt;
            ALU_SRL:    alu_res = op_a >> shamt;
            ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_MUL:    alu_res = acc_q;
            ALU_PASS_B: alu_res = op_b;
            default:    alu_res = '0;
        endcase
    end

    // Exceptions, control pass-through, branch resolution and valid/busy reporting
    always_comb begin
        mem_access = stage_q.mem_write || (stage_q.result_src == FROM_C);
        case (stage_q.data_size)
            SIZE_HALF: misaligned = alu_res[0];
            SIZE_WORD: misaligned = |alu_res[1:0];
            default:   misaligned = 1'b0;
        endcase

        if (stage_q.xcpt != XCPT_NONE) begin
            xcpt_out = stage_q.xcpt;
        end else if (mem_access && misaligned) begin
            xcpt_out = XCPT_ADDR_MISALIGN;
        end else begin
            xcpt_out = XCPT_NONE;
        end

        alu_res_out      = alu_res;
        write_data_out   = stage_q.rs2;
        pc_plus4_out     = stage_q.pc + XLEN'(4);
        rd_out           = stage_q.rd;
        result_src_out   = stage_q.result_src;
        data_size_out    = stage_q.data_size;
        reg_write_out    = stage_q.reg_write && (xcpt_out == XCPT_NONE);
        mem_write_out    = stage_q.mem_write && (xcpt_out == XCPT_NONE);
        busy_out         = busy;
        alu_valid_out    = stage_q.valid && !busy && (stage_q.result_src != FROM_C);
        branch_taken_out = stage_q.valid && (xcpt_out == XCPT_NONE) &&
                           (stage_q.jump || (stage_q.branch && ((op_a - op_b) == '0)));
        if (stage_q.jump && stage_q.alu_src) begin
            branch_target_out = (op_a + stage_q.imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end else begin
            branch_target_out = stage_q.pc + stage_q.imm;
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// tb/tb_alu_stage.sv - scoreboard bench for alu_stage with random and directed instructions
`timescale 1ns/1ps

module tb_alu_stage;
    import alu_stage_pkg::*;

    typedef struct packed {
        logic [31:0] rs1, rs2, imm, pc;
        alu_op_e     op;
        logic        src, br, jmp;
        logic [4:0]  rd;
        logic        rw, mw;
        result_src_e rsrc;
        data_size_e  dsize;
        xcpt_e       xc;
    } inst_t;

    typedef struct packed {
        logic [31:0] res, wdata, pc4, target;
        logic [4:0]  rd;
        logic        rw, mw, valid, taken, is_mul;
        result_src_e rsrc;
        data_size_e  dsize;
        xcpt_e       xc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, stall_in, flush_in;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    alu_op_e     alu_op;
    logic        alu_src, branch, jump;
    logic [4:0]  rd;
    logic        reg_write, mem_write;
    result_src_e result_src;
    data_size_e  data_size;
    xcpt_e       xcpt;

    logic [31:0] alu_res_out, write_data_out, pc_plus4_out, branch_target_out;
    logic        alu_valid_out, reg_write_out, mem_write_out, branch_taken_out, busy_out;
    logic [4:0]  rd_out;
    result_src_e result_src_out;
    data_size_e  data_size_out;
    xcpt_e       xcpt_out;

    alu_stage dut (
        .clk(clk), .reset(reset_n), .stall_in(stall_in), .flush_in(flush_in),
        .rs1_data_in(rs1_data), .rs2_data_in(rs2_data), .imm_in(imm), .pc_in(pc),
        .alu_op_in(alu_op), .alu_src_in(alu_src), .branch_in(branch), .jump_in(jump),
        .rd_in(rd), .reg_write_in(reg_write), .mem_write_in(mem_write),
        .result_src_in(result_src), .data_size_in(data_size), .xcpt_in(xcpt),
        .alu_res_out(alu_res_out), .write_data_out(write_data_out), .pc_plus4_out(pc_plus4_out),
        .alu_valid_out(alu_valid_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
        .mem_write_out(mem_write_out), .result_src_out(result_src_out),
        .data_size_out(data_size_out), .xcpt_out(xcpt_out),
        .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
        .busy_out(busy_out)
    );

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input inst_t i);
        exp_t        e;
        logic [31:0] a, b, ones;
        logic [63:0] prod;
        int unsigned sh;
        e    = '0;
        a    = i.rs1;
        b    = i.src ? i.imm : i.rs2;
        sh   = b % 32;
        ones = 32'hFFFF_FFFF;
        case (i.op)
            ALU_ADD:    e.res = a + b;
            ALU_SUB:    e.res = a - b;
            ALU_AND:    e.res = a & b;
            ALU_OR:     e.res = a | b;
            ALU_XOR:    e.res = a ^ b;
            ALU_SLL:    e.res = a << sh;
            ALU_SRL:    e.res = a >> sh;
            ALU_SRA:    e.res = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
            ALU_SLT:    e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:   e.res = (a < b) ? 32'd1 : 32'd0;
            ALU_MUL:    begin prod = {32'h0, a} * {32'h0, b}; e.res = prod[31:0]; end
            ALU_PASS_B: e.res = b;
            default:    e.res = 32'h0;
        endcase
        e.xc = i.xc;
        if (i.xc == XCPT_NONE && (i.mw || i.rsrc == FROM_C) &&
            ((i.dsize == SIZE_HALF && e.res % 2 != 0) || (i.dsize == SIZE_WORD && e.res % 4 != 0)))
            e.xc = XCPT_ADDR_MISALIGN;
        e.rw     = i.rw && e.xc == XCPT_NONE;
        e.mw     = i.mw && e.xc == XCPT_NONE;
        e.wdata  = i.rs2;
        e.pc4    = i.pc + 4;
        e.rd     = i.rd;
        e.rsrc   = i.rsrc;
        e.dsize  = i.dsize;
        e.valid  = i.rsrc != FROM_C;
        e.taken  = e.xc == XCPT_NONE && (i.jmp || (i.br && a == b));
        e.target = (i.jmp && i.src) ? ((a + i.imm) & ~32'd1) : (i.pc + i.imm);
        e.is_mul = i.op == ALU_MUL;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e     = '0;
        e.pc4 = 32'd4;
        return e;
    endfunction

    function automatic inst_t mk(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] p, input logic s);
        inst_t i;
        i = '0;
        i.op = op; i.rs1 = a; i.rs2 = b; i.imm = im; i.pc = p; i.src = s;
        i.rd = 5'd1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic inst_t rand_inst();
        inst_t i;
        i       = '0;
        i.op    = alu_op_e'($urandom_range(0, 11));
        i.rs1   = $urandom();
        i.rs2   = ($urandom_range(0, 3) == 0) ? i.rs1 : $urandom();
        i.imm   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 64) : $urandom();
        i.pc    = $urandom() & 32'hFFFF_FFFC;
        i.src   = 1'($urandom_range(0, 1));
        i.br    = ($urandom_range(0, 3) == 0);
        i.jmp   = ($urandom_range(0, 7) == 0);
        i.rd    = 5'($urandom_range(0, 31));
        i.rw    = 1'($urandom_range(0, 1));
        i.mw    = ($urandom_range(0, 3) == 0);
        i.rsrc  = result_src_e'($urandom_range(0, 2));
        i.dsize = data_size_e'($urandom_range(0, 2));
        i.xc    = ($urandom_range(0, 7) == 0) ? xcpt_e'($urandom_range(1, 3)) : XCPT_NONE;
        return i;
    endfunction

    task automatic drive(input inst_t i);
        rs1_data = i.rs1; rs2_data = i.rs2; imm = i.imm; pc = i.pc;
        alu_op = i.op; alu_src = i.src; branch = i.br; jump = i.jmp;
        rd = i.rd; reg_write = i.rw; mem_write = i.mw;
        result_src = i.rsrc; data_size = i.dsize; xcpt = i.xc;
    endtask

    task automatic issue(input inst_t i);
        int guard;
        @(negedge clk);
        drive(i);
        exp_q.push_back(model(i));
        guard = 0;
        forever begin
            stall_in = ($urandom_range(0, 4) == 0);
            #1;
            if (!stall_in && !busy_out) break;
            guard++;
            if (guard > 60) begin
                total++; bad++;
                $display("FAIL issue_timeout act=busy_out=%0b exp=accepted within 60 cycles", busy_out);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_flush(input int wait_cycles);
        repeat (wait_cycles) begin @(negedge clk); stall_in = 1'b1; end
        @(negedge clk);
        flush_in = 1'b1;
        stall_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        stall_in = 1'b1;
    endtask

    task automatic do_reset(input int wait_cycles);
        repeat (wait_cycles) begin @(negedge clk); stall_in = 1'b1; end
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        stall_in = 1'b1;
    endtask

    exp_t cur, nxt;
    logic have_cur = 1'b0;
    logic have_nxt = 1'b0;
    int   age = 0;

    task automatic check_cur(input exp_t e, input int a);
        logic eb;
        eb = e.is_mul && a < 4;
        chk("busy", busy_out, eb);
        if (eb) begin
            chk("valid_while_busy", alu_valid_out, 0);
        end else begin
            chk("alu_res", alu_res_out, e.res);
            chk("alu_valid", alu_valid_out, e.valid);
            chk("write_data", write_data_out, e.wdata);
            chk("pc_plus4", pc_plus4_out, e.pc4);
            chk("rd", rd_out, e.rd);
            chk("reg_write", reg_write_out, e.rw);
            chk("mem_write", mem_write_out, e.mw);
            chk("result_src", result_src_out, e.rsrc);
            chk("data_size", data_size_out, e.dsize);
            chk("xcpt", xcpt_out, e.xc);
            chk("branch_taken", branch_taken_out, e.taken);
            chk("branch_target", branch_target_out, e.target);
        end
    endtask

    // Monitor: compare what the register presents, then note what the next edge loads
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (have_nxt) begin
                cur = nxt; have_cur = 1'b1; have_nxt = 1'b0; age = 0;
            end else begin
                age++;
            end
            if (have_cur) check_cur(cur, age);
            if (!reset_n || flush_in) begin
                nxt = bubble(); have_nxt = 1'b1;
            end else if (!stall_in && !busy_out) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_underflow act=load exp=no load");
                end else begin
                    nxt = exp_q.pop_front(); have_nxt = 1'b1;
                end
            end
        end
    end

    initial begin
        inst_t i;
        reset_n = 1'b0; stall_in = 1'b1; flush_in = 1'b0;
        drive('0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        i = mk(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h40, 1'b0); issue(i);
        i = mk(ALU_SRA, 32'h8000_0000, 32'h21, 32'h0, 32'h44, 1'b0); issue(i);
        i = mk(ALU_MUL, 32'h0001_2345, 32'h100, 32'h0, 32'h48, 1'b0); issue(i);
        i = mk(ALU_SUB, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0); i.br = 1'b1; i.rw = 1'b0; issue(i);
        i = mk(ALU_ADD, 32'h203, 32'h0, 32'h0, 32'h104, 1'b1); i.jmp = 1'b1; i.rsrc = FROM_PC4; issue(i);
        i = mk(ALU_ADD, 32'h1000, 32'hABCD, 32'h2, 32'h108, 1'b1);
        i.mw = 1'b1; i.rw = 1'b0; i.dsize = SIZE_WORD; issue(i);
        i.xc = XCPT_ILLEGAL; issue(i);
        i = mk(ALU_MUL, 32'd7, 32'd9, 32'h0, 32'h10C, 1'b0); issue(i);
        do_flush(1);
        i = mk(ALU_MUL, 32'h1111, 32'h2222, 32'h0, 32'h110, 1'b0); issue(i);
        do_reset(2);
        i = mk(ALU_ADD, 32'd3, 32'd4, 32'h0, 32'h114, 1'b0); issue(i);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) do_flush($urandom_range(0, 3));
            else issue(rand_inst());
        end

        do_flush(0);
        repeat (3) begin @(negedge clk); stall_in = 1'b1; end
        chk("scoreboard_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
